multi_digit_hex_scan: RTL and testbench
=======================================

MULTI_DIGIT_HEX_SCAN -- requirements
Module: multi_digit_hex_scan

Interface
REQ-001 Parameter DIGITS, default 4: number of multiplexed seven-segment digits, legal range 1..8.
REQ-002 Parameter SCAN_DIV, default 50000: clock cycles per digit slot, legal range 2..2^20.
REQ-003 Parameter LZ_BLANK, default 1: 1 enables leading-zero blanking; 0 disables it.
REQ-004 clk  input  1  single system clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 value  input  4*DIGITS  hex digits to show; nibble i drives digit i, digit 0 least significant.
REQ-007 dp  input  DIGITS  decimal-point request per digit, active-high.
REQ-008 load  input  1  single-cycle strobe that captures value and dp into the shadow registers.
REQ-009 seg  output  8  segment drive, active-low; bit7 = dp, bits 6..0 = g..a.
REQ-010 dig  output  DIGITS  digit enable, active-low, at most one bit low at a time.

Function
REQ-011 Shadow registers SHALL capture value and dp on any cycle with load=1; the display SHALL read only the shadow copies.
REQ-012 Prescaler cnt SHALL count 0..SCAN_DIV-1 and wrap to 0; tick = (cnt == SCAN_DIV-1).
REQ-013 Digit index idx SHALL advance on tick, wrapping from DIGITS-1 to 0.
REQ-014 seg and dig SHALL be registered; on the edge ending a tick cycle they SHALL go blank (seg=8'hFF, dig all 1s) for one cycle (anti-ghosting dead time).
REQ-015 On every other edge, dig SHALL be all 1s except bit idx=0, and seg SHALL be {~dp_sh[idx], decode(nibble idx)}.
REQ-016 Each digit SHALL therefore be lit SCAN_DIV-1 cycles out of every SCAN_DIV; one full frame = DIGITS*SCAN_DIV cycles.
REQ-017 Decode (bits 6..0 with bit7=1): 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=98 A=88 b=83 C=A7 d=A1 E=86 F=8E (hex).
REQ-018 With LZ_BLANK=1, digit i>0 SHALL show segments 6..0 off when all nibbles i..DIGITS-1 are zero; digit 0 is never blanked; dp still honoured on blanked digits.
REQ-019 A load coinciding with tick SHALL take effect; the new shadow content is used from the next cycle onward.
REQ-020 A load mid-slot SHALL change seg from the second edge after the load; idx and cnt are unaffected by load.
REQ-021 With DIGITS=1, idx SHALL stay 0 and the dead cycle SHALL still occur every SCAN_DIV cycles.

Reset
REQ-022 While rst=1: cnt=0, idx=0, shadow value=0, shadow dp=0, seg=8'hFF, dig all 1s.
REQ-023 rst SHALL override load and tick in the same cycle; a reset mid-frame SHALL restart at digit 0 with a full slot.
REQ-024 First edge after rst deasserts SHALL drive digit 0 showing "0" (seg=8'hC0, dig bit0 low).

Structure
REQ-025 Shared package seg7_pkg SHALL hold SEG_OFF (8'hFF), the 16-entry decode table, and a clog2-style width helper for cnt and idx.
REQ-026 Sub-module hex_seg_dec (combinational, 4-bit in, 7-bit active-low out) SHALL implement REQ-017 and be instantiated once on the selected nibble.
REQ-027 No latches; a single clocked process with synchronous reset for all state.

Verification (DIGITS=4, SCAN_DIV=4, LZ_BLANK=1 unless stated)
REQ-028 Reset release, no load -> dig=1110, seg=C0 for 3 cycles, then dig=1111/seg=FF for 1 cycle, digits 1..3 blanked (seg=FF, dig low).
REQ-029 load value=16'h12AF, dp=4'b0100 -> over one frame: d0 seg=8E, d1 seg=88, d2 seg=24 (dp on), d3 seg=F9; one dead cycle between each.
REQ-030 load value=16'h0030, LZ_BLANK=1 -> d3 and d2 seg=FF, d1 seg=B0, d0 seg=C0; repeat with LZ_BLANK=0 -> d3, d2 seg=C0.
REQ-031 load asserted on a tick cycle with value=16'h0005 -> next lit slot shows new data; no dig pattern with two bits low ever observed.
REQ-032 rst pulse while idx=2, cnt=1 -> outputs FF/1111 during rst, then digit 0 lit for 3 cycles; shadow cleared to 0.
REQ-033 Exhaustive nibble sweep 0..F via load on d0 -> seg matches REQ-017 table for every value.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared seven-segment constants: blank pattern, hex glyph table and a register-width helper.
package seg7_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low glyphs for bits 6..0 (g..a), indexed by nibble value.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h18, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E
    };

    // Smallest width (at least 1) whose range covers n distinct values.
    function automatic int unsigned width_of(input int unsigned n);
        int unsigned w;
        w = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/hex_seg_dec.sv
// Combinational hex nibble to active-low seven-segment decoder (bits 6..0 = g..a).
module hex_seg_dec
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segs
);

    assign segs = SEG_TABLE[nibble];

endmodule

// File: rtl/multi_digit_hex_scan.sv
// Time-multiplexed hex display driver with shadow registers, leading-zero blanking and a
// one-cycle blank between digit slots to suppress ghosting.
module multi_digit_hex_scan
    import seg7_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000,
    parameter int LZ_BLANK = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  load,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     dig
);

    localparam int unsigned CNT_W = width_of(SCAN_DIV);
    localparam int unsigned IDX_W = width_of(DIGITS);

    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic [4*DIGITS-1:0] value_sh;
    logic [DIGITS-1:0]   dp_sh;

    logic       tick;
    logic [3:0] nib_sel;
    logic       dp_sel;
    logic       lz_sel;
    logic       all_zero;
    logic [6:0] seg_dec;
    logic [6:0] seg_lit;

    assign tick = (cnt == CNT_W'(SCAN_DIV - 1));

    // Walk from the top digit down so all_zero means "this nibble and every one above it".
    always_comb begin
        nib_sel  = 4'h0;
        dp_sel   = 1'b0;
        lz_sel   = 1'b0;
        all_zero = 1'b1;
        for (int j = DIGITS - 1; j >= 0; j--) begin
            all_zero = all_zero & (value_sh[4*j +: 4] == 4'h0);
            if (idx == IDX_W'(j)) begin
                nib_sel = value_sh[4*j +: 4];
                dp_sel  = dp_sh[j];
                lz_sel  = all_zero & (j != 0);
            end
        end
    end

    hex_seg_dec u_dec (
        .nibble (nib_sel),
        .segs   (seg_dec)
    );

    assign seg_lit = ((LZ_BLANK != 0) && lz_sel) ? SEG_OFF[6:0] : seg_dec;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            idx      <= '0;
            value_sh <= '0;
            dp_sh    <= '0;
            seg      <= SEG_OFF;
            dig      <= '1;
        end else begin
            if (load) begin
                value_sh <= value;
                dp_sh    <= dp;
            end
            if (tick) begin
                cnt <= '0;
                idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
                seg <= SEG_OFF;
                dig <= '1;
            end else begin
                cnt <= cnt + 1'b1;
                seg <= {~dp_sel, seg_lit};
                dig <= ~(DIGITS'(1) << idx);
            end
        end
    end

endmodule

// File: tb/tb_multi_digit_hex_scan.sv
// Randomized self-checking bench: three scanner configurations against an arithmetic
// frame-position reference model.
module tb_multi_digit_hex_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp;

    logic [7:0] seg, seg_n, seg_1;
    logic [3:0] dig, dig_n;
    logic [0:0] dig_1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    multi_digit_hex_scan #(.DIGITS(4), .SCAN_DIV(4), .LZ_BLANK(1)) dut (
        .clk(clk), .rst(rst), .value(value), .dp(dp), .load(load), .seg(seg), .dig(dig)
    );

    multi_digit_hex_scan #(.DIGITS(4), .SCAN_DIV(4), .LZ_BLANK(0)) dut_nlz (
        .clk(clk), .rst(rst), .value(value), .dp(dp), .load(load), .seg(seg_n), .dig(dig_n)
    );

    multi_digit_hex_scan #(.DIGITS(1), .SCAN_DIV(3), .LZ_BLANK(1)) dut_one (
        .clk(clk), .rst(rst), .value(value[3:0]), .dp(dp[0:0]), .load(load), .seg(seg_1),
        .dig(dig_1)
    );

    // Full 8-bit glyphs with dp off.
    logic [7:0] glyph [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h98, 8'h88, 8'h83, 8'hA7, 8'hA1, 8'h86, 8'h8E
    };

    // Output after edge k (counted from reset release): position within the frame decides
    // which digit is lit, the last cycle of each slot is dark.
    function automatic logic [7:0] ref_seg(input int k, input logic [15:0] v,
                                           input logic [3:0] d, input int nd, input int sd,
                                           input bit lz);
        int pos, digit, phase;
        logic [15:0] upper;
        logic [7:0]  s;
        pos   = k % (nd * sd);
        digit = pos / sd;
        phase = pos % sd;
        if (phase == sd - 1) return 8'hFF;
        upper = v >> (4 * digit);
        s = glyph[upper[3:0]];
        if (lz && digit > 0 && upper == 16'h0) s = 8'hFF;
        s[7] = ~d[digit];
        return s;
    endfunction

    function automatic logic [7:0] ref_dig(input int k, input int nd, input int sd);
        int pos;
        pos = k % (nd * sd);
        if (pos % sd == sd - 1) return 8'hFF;
        return ~(8'd1 << (pos / sd));
    endfunction

    int          k;
    logic [15:0] mval;
    logic [3:0]  mdp;
    logic [7:0]  e_seg, e_seg_n, e_seg_1;
    logic [3:0]  e_dig, e_dig_n;
    logic [0:0]  e_dig_1;

    always @(posedge clk) begin
        if (rst) begin
            k       <= 0;
            mval    <= '0;
            mdp     <= '0;
            e_seg   <= 8'hFF;
            e_seg_n <= 8'hFF;
            e_seg_1 <= 8'hFF;
            e_dig   <= '1;
            e_dig_n <= '1;
            e_dig_1 <= '1;
        end else begin
            e_seg   <= ref_seg(k, mval, mdp, 4, 4, 1'b1);
            e_seg_n <= ref_seg(k, mval, mdp, 4, 4, 1'b0);
            e_seg_1 <= ref_seg(k, {12'h0, mval[3:0]}, {3'b0, mdp[0]}, 1, 3, 1'b1);
            e_dig   <= 4'(ref_dig(k, 4, 4));
            e_dig_n <= 4'(ref_dig(k, 4, 4));
            e_dig_1 <= 1'(ref_dig(k, 1, 3));
            k <= k + 1;
            if (load) begin
                mval <= value;
                mdp  <= dp;
            end
        end
    end

    task automatic test_reset();
        logic [3:0] xd;
        logic [7:0] xs;
        rst = 1'b1; load = 1'b0; value = '0; dp = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (seg !== 8'hFF || dig !== 4'hF || seg_1 !== 8'hFF || dig_1 !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_hold: seg %h dig %b seg1 %h dig1 %b, need FF 1111 FF 1",
                     seg, dig, seg_1, dig_1);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            xd = (i % 4 == 3) ? 4'hF : ~(4'd1 << ((i / 4) % 4));
            xs = (i % 4 == 3 || (i / 4) % 4 != 0) ? 8'hFF : 8'hC0;
            n_cmp++;
            if (seg !== xs || dig !== xd || seg_n !== e_seg_n || seg_1 !== e_seg_1 ||
                dig_1 !== e_dig_1) begin
                n_bad++;
                $display("FAIL reset_release cyc %0d: seg %h dig %b nlz %h one %h/%b, need %h %b %h %h/%b",
                         i, seg, dig, seg_n, seg_1, dig_1, xs, xd, e_seg_n, e_seg_1, e_dig_1);
            end
        end
    endtask

    task automatic test_frame_12af();
        logic [7:0] lit [4] = '{8'h8E, 8'h88, 8'h24, 8'hF9};
        logic [3:0] pat;
        value = 16'h12AF; dp = 4'b0100; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 34; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({seg, dig, seg_n, dig_n, seg_1, dig_1} !==
                {e_seg, e_dig, e_seg_n, e_dig_n, e_seg_1, e_dig_1}) begin
                n_bad++;
                $display("FAIL frame_12af cyc %0d: seg %h/%h/%h dig %b/%b/%b, need %h/%h/%h %b/%b/%b",
                         i, seg, seg_n, seg_1, dig, dig_n, dig_1,
                         e_seg, e_seg_n, e_seg_1, e_dig, e_dig_n, e_dig_1);
            end
            for (int j = 0; j < 4; j++) begin
                pat = ~(4'd1 << j);
                if (dig === pat) begin
                    n_cmp++;
                    if (seg !== lit[j]) begin
                        n_bad++;
                        $display("FAIL frame_12af_digit%0d: seg %h, need %h", j, seg, lit[j]);
                    end
                end
            end
        end
    endtask

    task automatic test_lz();
        logic [7:0] lz_on  [4] = '{8'hC0, 8'hB0, 8'hFF, 8'hFF};
        logic [7:0] lz_off [4] = '{8'hC0, 8'hB0, 8'hC0, 8'hC0};
        logic [3:0] pat;
        value = 16'h0030; dp = 4'b0000; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 34; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({seg, dig, seg_n, dig_n, seg_1, dig_1} !==
                {e_seg, e_dig, e_seg_n, e_dig_n, e_seg_1, e_dig_1}) begin
                n_bad++;
                $display("FAIL lz_model cyc %0d: seg %h/%h/%h dig %b/%b/%b, need %h/%h/%h %b/%b/%b",
                         i, seg, seg_n, seg_1, dig, dig_n, dig_1,
                         e_seg, e_seg_n, e_seg_1, e_dig, e_dig_n, e_dig_1);
            end
            for (int j = 0; j < 4; j++) begin
                pat = ~(4'd1 << j);
                if (dig === pat) begin
                    n_cmp++;
                    if (seg !== lz_on[j] || seg_n !== lz_off[j]) begin
                        n_bad++;
                        $display("FAIL lz_digit%0d: seg %h nlz %h, need %h %h",
                                 j, seg, seg_n, lz_on[j], lz_off[j]);
                    end
                end
            end
        end
    endtask

    task automatic test_load_on_tick();
        int guard;
        guard = 0;
        while (k % 4 != 3 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (k % 4 != 3) begin
            n_bad++;
            $display("FAIL tick_wait: no tick cycle found, phase %0d need 3", k % 4);
        end
        value = 16'h0005; dp = 4'($urandom); load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        n_cmp++;
        if (seg !== 8'hFF || dig !== 4'hF) begin
            n_bad++;
            $display("FAIL tick_dead: seg %h dig %b, need FF 1111", seg, dig);
        end
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({seg, dig, seg_n, dig_n, seg_1, dig_1} !==
                {e_seg, e_dig, e_seg_n, e_dig_n, e_seg_1, e_dig_1}) begin
                n_bad++;
                $display("FAIL tick_load cyc %0d: seg %h/%h/%h dig %b/%b/%b, need %h/%h/%h %b/%b/%b",
                         i, seg, seg_n, seg_1, dig, dig_n, dig_1,
                         e_seg, e_seg_n, e_seg_1, e_dig, e_dig_n, e_dig_1);
            end
            n_cmp++;
            if ($countones(~dig) > 1 || $countones(~dig_n) > 1) begin
                n_bad++;
                $display("FAIL tick_onehot cyc %0d: dig %b nlz %b, need at most one low",
                         i, dig, dig_n);
            end
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        guard = 0;
        while (k % 16 != 9 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if (seg !== 8'hFF || dig !== 4'hF || seg_n !== 8'hFF || dig_n !== 4'hF) begin
                n_bad++;
                $display("FAIL rst_mid_hold: seg %h dig %b nlz %h %b, need FF 1111",
                         seg, dig, seg_n, dig_n);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            n_cmp++;
            if (i < 3 && (seg !== 8'hC0 || dig !== 4'hE)) begin
                n_bad++;
                $display("FAIL rst_mid_digit0 cyc %0d: seg %h dig %b, need C0 1110", i, seg, dig);
            end else if (i == 3 && (seg !== 8'hFF || dig !== 4'hF)) begin
                n_bad++;
                $display("FAIL rst_mid_dead: seg %h dig %b, need FF 1111", seg, dig);
            end else if ({seg, dig, seg_n, dig_n, seg_1, dig_1} !==
                         {e_seg, e_dig, e_seg_n, e_dig_n, e_seg_1, e_dig_1}) begin
                n_bad++;
                $display("FAIL rst_mid cyc %0d: seg %h/%h/%h dig %b/%b/%b, need %h/%h/%h %b/%b/%b",
                         i, seg, seg_n, seg_1, dig, dig_n, dig_1,
                         e_seg, e_seg_n, e_seg_1, e_dig, e_dig_n, e_dig_1);
            end
        end
    endtask

    task automatic test_sweep();
        bit seen;
        for (int n = 0; n < 16; n++) begin
            value = (16'($urandom) & 16'hFFF0) | 16'(n);
            dp = 4'b0000; load = 1'b1;
            @(negedge clk);
            load = 1'b0;
            seen = 1'b0;
            for (int i = 0; i < 17; i++) begin
                @(negedge clk);
                n_cmp++;
                if ({seg, dig, seg_n, dig_n, seg_1, dig_1} !==
                    {e_seg, e_dig, e_seg_n, e_dig_n, e_seg_1, e_dig_1}) begin
                    n_bad++;
                    $display("FAIL sweep_model n=%h cyc %0d: seg %h/%h/%h, need %h/%h/%h",
                             n, i, seg, seg_n, seg_1, e_seg, e_seg_n, e_seg_1);
                end
                if (!seen && dig === 4'hE) begin
                    seen = 1'b1;
                    n_cmp++;
                    if (seg !== glyph[n]) begin
                        n_bad++;
                        $display("FAIL sweep_glyph n=%h: seg %h, need %h", n, seg, glyph[n]);
                    end
                end
            end
            if (!seen) begin
                n_bad++;
                $display("FAIL sweep_digit0 n=%h: digit 0 never lit, need lit within 17 cycles",
                         n);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                load  = 1'b1;
                value = 16'($urandom);
                dp    = 4'($urandom);
                if ($urandom_range(0, 1) == 0) value = value & 16'h00FF;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
            n_cmp++;
            if ({seg, dig, seg_n, dig_n, seg_1, dig_1} !==
                {e_seg, e_dig, e_seg_n, e_dig_n, e_seg_1, e_dig_1}) begin
                n_bad++;
                $display("FAIL random cyc %0d: seg %h/%h/%h dig %b/%b/%b, need %h/%h/%h %b/%b/%b",
                         i, seg, seg_n, seg_1, dig, dig_n, dig_1,
                         e_seg, e_seg_n, e_seg_1, e_dig, e_dig_n, e_dig_1);
            end
        end
        load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; value = '0; dp = '0;
        test_reset();
        test_frame_12af();
        test_lz();
        test_load_on_tick();
        test_reset_mid();
        test_sweep();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
